// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard: per-register outstanding-write counters gate uop issue.
// Latency: hold/issue combinational; counters/flags update one edge later. Backpressure: source_not_ready holds decode.
module issue_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int CNT_WIDTH      = 2,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      system_flush,
  input  logic                      system_stall,
  input  logic                      uop_valid_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      rs1_valid,
  input  logic                      rs2_valid,
  input  logic                      rd_valid,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      source_not_ready,
  output logic                      issue_fire,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [7:0]                inflight_total,
  output logic                      hazard_timeout,
  output logic                      wb_underflow
);

  localparam int HZ_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [HZ_W-1:0] HZ_MAX = HZ_W'(TIMEOUT);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [HZ_W-1:0]      hz_cnt;
  logic raw1, raw2, sat, inc, dec, udf;

  always_comb begin
    raw1 = rs1_valid && (rs1 != '0) && (cnt[rs1] != '0);
    raw2 = rs2_valid && (rs2 != '0) && (cnt[rs2] != '0);
    sat  = rd_valid  && (rd  != '0) && (cnt[rd] == CNT_MAX);
    source_not_ready = uop_valid_decode && (raw1 || raw2 || sat) && !system_flush;
    issue_fire = uop_valid_decode && !source_not_ready && !system_stall && !system_flush;
    inc = issue_fire && rd_valid && (rd != '0);
    // Writeback only retires a real outstanding write; a zero counter flags an error instead.
    dec = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != '0);
    udf = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (system_flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        // An issue and a retire on the same register cancel out.
        if (inc && (rd == REG_ADDR_WIDTH'(i)) && !(dec && (wb_rd == REG_ADDR_WIDTH'(i))))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec && (wb_rd == REG_ADDR_WIDTH'(i)) && !(inc && (rd == REG_ADDR_WIDTH'(i))))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_total <= '0;
      hz_cnt         <= '0;
      hazard_timeout <= 1'b0;
      wb_underflow   <= 1'b0;
    end else if (system_flush) begin
      inflight_total <= '0;
      hz_cnt         <= '0;
      hazard_timeout <= 1'b0;
      wb_underflow   <= 1'b0;
    end else begin
      inflight_total <= inflight_total + 8'(inc) - 8'(dec);
      if (!source_not_ready)
        hz_cnt <= '0;
      else if (hz_cnt != HZ_MAX)
        hz_cnt <= hz_cnt + 1'b1;
      if (hz_cnt == HZ_MAX)
        hazard_timeout <= 1'b1;
      if (udf)
        wb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomised and directed stimulus for issue_scoreboard against a counting reference model.
module tb_issue_scoreboard;

  logic clk = 1'b0;
  logic reset_n;
  logic system_flush, system_stall, uop_valid_decode;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic rs1_valid, rs2_valid, rd_valid, wb_valid;
  logic source_not_ready, issue_fire, hazard_timeout, wb_underflow;
  logic [31:0] busy_vec;
  logic [7:0] inflight_total;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  int m_cnt [32];
  int m_total, m_hz;
  bit m_tmo, m_udf;
  bit s_snr, s_fire;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .system_flush(system_flush), .system_stall(system_stall),
    .uop_valid_decode(uop_valid_decode), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .source_not_ready(source_not_ready),
    .issue_fire(issue_fire), .busy_vec(busy_vec), .inflight_total(inflight_total),
    .hazard_timeout(hazard_timeout), .wb_underflow(wb_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_total = 0; m_hz = 0; m_tmo = 0; m_udf = 0;
  endtask

  function automatic logic [31:0] exp_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic check_regs();
    check("busy_vec", busy_vec, exp_busy());
    check("inflight_total", 32'(inflight_total), 32'(m_total));
    check("hazard_timeout", 32'(hazard_timeout), 32'(m_tmo));
    check("wb_underflow", 32'(wb_underflow), 32'(m_udf));
  endtask

  task automatic idle_inputs();
    system_flush = 0; system_stall = 0; uop_valid_decode = 0;
    rs1 = 0; rs2 = 0; rd = 0; rs1_valid = 0; rs2_valid = 0; rd_valid = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  // Inputs are already applied; check comb outputs, advance one edge, check state.
  task automatic tick();
    bit raw1, raw2, sat, snr, fire, inc, dec;
    raw1 = rs1_valid && rs1 != 0 && m_cnt[rs1] != 0;
    raw2 = rs2_valid && rs2 != 0 && m_cnt[rs2] != 0;
    sat  = rd_valid && rd != 0 && m_cnt[rd] == 3;
    snr  = uop_valid_decode && (raw1 || raw2 || sat) && !system_flush;
    fire = uop_valid_decode && !snr && !system_stall && !system_flush;
    #1;
    check("source_not_ready", 32'(source_not_ready), 32'(snr));
    check("issue_fire", 32'(issue_fire), 32'(fire));
    s_snr = source_not_ready;
    s_fire = issue_fire;
    if (system_flush) begin
      model_clear();
    end else begin
      inc = fire && rd_valid && rd != 0;
      dec = wb_valid && wb_rd != 0 && m_cnt[wb_rd] != 0;
      if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_udf = 1;
      if (inc) m_cnt[rd]++;
      if (dec) m_cnt[wb_rd]--;
      m_total = m_total + int'(inc) - int'(dec);
      if (m_hz == 64) m_tmo = 1;
      m_hz = snr ? ((m_hz < 64) ? m_hz + 1 : 64) : 0;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic uop(input bit v, input int s1, input bit s1v, input int s2, input bit s2v,
                     input int d, input bit dv);
    uop_valid_decode = v;
    rs1 = 5'(s1); rs1_valid = s1v;
    rs2 = 5'(s2); rs2_valid = s2v;
    rd = 5'(d); rd_valid = dv;
  endtask

  task automatic flush_now();
    idle_inputs();
    system_flush = 1;
    tick();
    system_flush = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset_n = 0;
    #12 reset_n = 1;
    @(posedge clk); #1;
    check_regs();

    // independent stream
    uop(1, 1, 1, 2, 1, 3, 1); tick(); check("ind_fire0", 32'(s_fire), 1);
    uop(1, 5, 1, 6, 1, 4, 1); tick(); check("ind_fire1", 32'(s_fire), 1);
    idle_inputs();
    check("ind_busy", busy_vec, 32'h18);
    check("ind_total", 32'(inflight_total), 2);
    flush_now();

    // RAW hold and release one cycle after writeback
    uop(1, 0, 0, 0, 0, 3, 1); tick();
    uop(1, 3, 1, 0, 0, 8, 1); tick(); check("raw_hold", 32'(s_snr), 1);
    tick();
    wb_valid = 1; wb_rd = 3; tick(); check("raw_hold_wb", 32'(s_snr), 1);
    wb_valid = 0; tick(); check("raw_release", 32'(s_fire), 1);
    // x0 and unused fields
    uop(1, 0, 0, 0, 0, 0, 1); tick();
    uop(1, 0, 1, 8, 0, 0, 0); tick(); check("x0_nohold", 32'(s_snr), 0);
    check("x0_busy", 32'(busy_vec[0]), 0);
    flush_now();

    // saturation, with a writeback landing in the held cycle
    for (int i = 0; i < 3; i++) begin uop(1, 0, 0, 0, 0, 7, 1); tick(); end
    tick(); check("sat_hold", 32'(s_snr), 1);
    wb_valid = 1; wb_rd = 7; tick(); check("sat_hold_wb", 32'(s_snr), 1);
    wb_valid = 0; tick(); check("sat_issue", 32'(s_fire), 1);
    check("sat_total", 32'(inflight_total), 3);
    flush_now();

    // hazard timeout
    uop(1, 0, 0, 0, 0, 10, 1); tick();
    uop(1, 10, 1, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) tick();
    check("tmo_not_yet", 32'(hazard_timeout), 0);
    tick();
    check("tmo_set", 32'(hazard_timeout), 1);
    // underflow on an idle register
    idle_inputs(); wb_valid = 1; wb_rd = 9; tick();
    check("udf_set", 32'(wb_underflow), 1);
    check("udf_total", 32'(inflight_total), 1);
    wb_valid = 0;
    flush_now();

    // flush with a concurrent writeback
    uop(1, 0, 0, 0, 0, 3, 1); tick();
    uop(1, 0, 0, 0, 0, 7, 1); tick();
    check("fl_busy_pre", busy_vec, 32'h88);
    uop(1, 0, 0, 0, 0, 4, 1); wb_valid = 1; wb_rd = 3; system_flush = 1; tick();
    check("fl_fire", 32'(s_fire), 0);
    check("fl_busy", busy_vec, 0);
    check("fl_total", 32'(inflight_total), 0);
    idle_inputs();

    // randomised traffic with occasional flushes and async resets
    for (int n = 0; n < 3000; n++) begin
      uop($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      wb_valid = $urandom_range(0, 1);
      wb_rd = 5'($urandom_range(0, 7));
      system_stall = ($urandom_range(0, 7) == 0);
      system_flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 0;
        #1;
        model_clear();
        check("async_rst_busy", busy_vec, 0);
        check("async_rst_total", 32'(inflight_total), 0);
        check("async_rst_flags", {30'b0, hazard_timeout, wb_underflow}, 0);
        reset_n = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
